// File: rtl/mem_access_stage_pkg.sv
// Shared constants for the memory-access stage: access-width codes,
// FSM state encodings, byte-enable patterns and bus widths.
package mem_access_stage_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int VREG_W = 5;
  localparam int PREG_W = 6;

  localparam logic [1:0] MEM_WIDTH_BYTE = 2'b00;
  localparam logic [1:0] MEM_WIDTH_HALF = 2'b01;
  localparam logic [1:0] MEM_WIDTH_WORD = 2'b10;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_WAIT = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory port: registered request side driven by the stage,
// read data and one-cycle ack returned by the memory.
interface mem_access_stage_if;
  import mem_access_stage_pkg::*;

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [3:0]        be;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;

  modport master (output req, we, addr, be, wdata, input rdata, ack);
  modport slave  (input req, we, addr, be, wdata, output rdata, ack);

endinterface

// File: rtl/mem_access_stage_align.sv
// Combinational lane logic: byte enables and replicated store data,
// load lane extraction with sign/zero extension, misalignment detection.
module mem_access_stage_align
  import mem_access_stage_pkg::*;
(
  input  logic [1:0]        addr_lo,
  input  logic [1:0]        mem_width,
  input  logic              sign_extend,
  input  logic              mem_enable,
  input  logic [DATA_W-1:0] store_data,
  input  logic [DATA_W-1:0] rdata,
  output logic [3:0]        be,
  output logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] load_data,
  output logic              misaligned
);

  function automatic logic [DATA_W-1:0] extend_byte(input logic signed [7:0] b, input logic sx);
    logic signed [DATA_W-1:0] s;
    s = DATA_W'(b);
    return sx ? s : {{(DATA_W-8){1'b0}}, b};
  endfunction

  function automatic logic [DATA_W-1:0] extend_half(input logic signed [15:0] h, input logic sx);
    logic signed [DATA_W-1:0] s;
    s = DATA_W'(h);
    return sx ? s : {{(DATA_W-16){1'b0}}, h};
  endfunction

  // Lane selection for both directions; width code 11 behaves as a word.
  always_comb begin
    be        = BE_WORD;
    wdata     = store_data;
    load_data = rdata;
    case (mem_width)
      MEM_WIDTH_BYTE: begin
        be        = BE_BYTE0 << addr_lo;
        wdata     = {4{store_data[7:0]}};
        load_data = extend_byte(rdata[{addr_lo, 3'b000} +: 8], sign_extend);
      end
      MEM_WIDTH_HALF: begin
        be        = addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
        wdata     = {2{store_data[15:0]}};
        load_data = extend_half(addr_lo[1] ? rdata[31:16] : rdata[15:0], sign_extend);
      end
      MEM_WIDTH_WORD: begin
        be        = BE_WORD;
        wdata     = store_data;
        load_data = rdata;
      end
      default: begin
        be        = BE_WORD;
        wdata     = store_data;
        load_data = rdata;
      end
    endcase
  end

  // Halves need even addresses, words (and code 11) need word alignment.
  always_comb begin
    misaligned = mem_enable &
                 (((mem_width == MEM_WIDTH_HALF) & addr_lo[0]) |
                  (mem_width[1] & (addr_lo != 2'b00)));
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: issues one load/store per instruction on
// the req/ack data-memory port, stalls upstream until it completes, and
// selects the writeback value. A flush during an outstanding access lets
// the access finish but drops its result.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int FREE_LIST_WIDTH = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       pipe_stall,
  input  logic [31:0]                pc_in,
  input  logic [31:0]                inst_in,
  input  logic [ADDR_WIDTH-1:0]      alu_res_in,
  input  logic [1:0]                 mem_width_in,
  input  logic                       sign_extend_in,
  input  logic                       mem_rw_in,
  input  logic                       mem_enable_in,
  input  logic [DATA_WIDTH-1:0]      mem_write_in,
  input  logic                       wb_src_in,
  input  logic                       wb_reg_in,
  input  logic                       branch_in,
  input  logic [VREG_W-1:0]          virtual_write_addr_in,
  input  logic [PREG_W-1:0]          physical_write_addr_in,
  input  logic [FREE_LIST_WIDTH-1:0] active_list_index_in,
  mem_access_stage_if.master         dmem,
  output logic [DATA_WIDTH-1:0]      wb_data_out,
  output logic                       stall_req,
  output logic                       addr_error,
  output logic [31:0]                pc_out,
  output logic [31:0]                inst_out,
  output logic                       wb_reg_out,
  output logic                       branch_out,
  output logic [VREG_W-1:0]          virtual_write_addr_out,
  output logic [PREG_W-1:0]          physical_write_addr_out,
  output logic [FREE_LIST_WIDTH-1:0] active_list_index_out
);

  logic [1:0]            state;
  logic                  discard_q;
  logic [DATA_WIDTH-1:0] load_q;
  logic                  req_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [3:0]            be_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic [3:0]            be_c;
  logic [DATA_WIDTH-1:0] wdata_c;
  logic [DATA_WIDTH-1:0] load_c;
  logic                  misaligned;
  logic                  issue;

  mem_access_stage_align u_align (
    .addr_lo     (alu_res_in[1:0]),
    .mem_width   (mem_width_in),
    .sign_extend (sign_extend_in),
    .mem_enable  (mem_enable_in),
    .store_data  (mem_write_in),
    .rdata       (dmem.rdata),
    .be          (be_c),
    .wdata       (wdata_c),
    .load_data   (load_c),
    .misaligned  (misaligned)
  );

  // Start a new access only for a live, aligned memory instruction.
  always_comb begin
    issue     = mem_enable_in & ~misaligned & ~flush;
    stall_req = ((state == ST_IDLE) & issue) | (state == ST_WAIT);
  end

  // Access sequencer: IDLE -> WAIT (bus held) -> DONE, or back to IDLE when discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      discard_q <= 1'b0;
      load_q    <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (issue) begin
            state   <= ST_WAIT;
            req_q   <= 1'b1;
            we_q    <= mem_rw_in;
            addr_q  <= {alu_res_in[ADDR_WIDTH-1:2], 2'b00};
            be_q    <= be_c;
            wdata_q <= wdata_c;
          end
        end
        ST_WAIT: begin
          if (flush) begin
            discard_q <= 1'b1;
          end
          if (dmem.ack) begin
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            load_q    <= load_c;
            state     <= (discard_q | flush) ? ST_IDLE : ST_DONE;
            discard_q <= 1'b0;
          end
        end
        ST_DONE: begin
          if (flush || !pipe_stall) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Bus drive, writeback select and pass-through of the instruction's tags.
  always_comb begin
    dmem.req                = req_q;
    dmem.we                 = we_q;
    dmem.addr               = addr_q;
    dmem.be                 = be_q;
    dmem.wdata              = wdata_q;
    addr_error              = misaligned;
    wb_data_out             = (wb_src_in && (state == ST_DONE)) ? load_q : alu_res_in;
    wb_reg_out              = wb_reg_in & ~misaligned & ~discard_q;
    pc_out                  = pc_in;
    inst_out                = inst_in;
    branch_out              = branch_in;
    virtual_write_addr_out  = virtual_write_addr_in;
    physical_write_addr_out = physical_write_addr_in;
    active_list_index_out   = active_list_index_in;
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: table of aligned accesses with a request
// scoreboard, plus hand-written misalignment, flush, DONE-hold and reset cases.
module tb_mem_access_stage;
  import mem_access_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        pipe_stall;
  logic [31:0] pc_in, inst_in, alu_res_in, mem_write_in;
  logic [1:0]  mem_width_in;
  logic        sign_extend_in, mem_rw_in, mem_enable_in, wb_src_in, wb_reg_in, branch_in;
  logic [VREG_W-1:0] virtual_write_addr_in;
  logic [PREG_W-1:0] physical_write_addr_in;
  logic [2:0]        active_list_index_in;
  logic [31:0] wb_data_out, pc_out, inst_out;
  logic        stall_req, addr_error, wb_reg_out, branch_out;
  logic [VREG_W-1:0] virtual_write_addr_out;
  logic [PREG_W-1:0] physical_write_addr_out;
  logic [2:0]        active_list_index_out;

  always #5 clk = ~clk;

  mem_access_stage_if dmem_bus();

  mem_access_stage #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .FREE_LIST_WIDTH(3)) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .flush                   (flush),
    .pipe_stall              (pipe_stall),
    .pc_in                   (pc_in),
    .inst_in                 (inst_in),
    .alu_res_in              (alu_res_in),
    .mem_width_in            (mem_width_in),
    .sign_extend_in          (sign_extend_in),
    .mem_rw_in               (mem_rw_in),
    .mem_enable_in           (mem_enable_in),
    .mem_write_in            (mem_write_in),
    .wb_src_in               (wb_src_in),
    .wb_reg_in               (wb_reg_in),
    .branch_in               (branch_in),
    .virtual_write_addr_in   (virtual_write_addr_in),
    .physical_write_addr_in  (physical_write_addr_in),
    .active_list_index_in    (active_list_index_in),
    .dmem                    (dmem_bus),
    .wb_data_out             (wb_data_out),
    .stall_req               (stall_req),
    .addr_error              (addr_error),
    .pc_out                  (pc_out),
    .inst_out                (inst_out),
    .wb_reg_out              (wb_reg_out),
    .branch_out              (branch_out),
    .virtual_write_addr_out  (virtual_write_addr_out),
    .physical_write_addr_out (physical_write_addr_out),
    .active_list_index_out   (active_list_index_out)
  );

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  width;
    logic        sx;
    logic        rw;
    logic [31:0] wdat;
    logic [31:0] rdata;
    int          delay;
    int          hold;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_wb;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
  } bus_t;

  int   checks = 0;
  int   errors = 0;
  bus_t exp_q[$];
  logic req_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // Scoreboard: every new request must match the oldest expected one.
  always @(negedge clk) begin
    bus_t e;
    if (dmem_bus.req && !req_prev) begin
      if (exp_q.size() == 0) begin
        check("unexpected_req", {31'b0, dmem_bus.req}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("req_addr", dmem_bus.addr, e.addr);
        check("req_be", {28'b0, dmem_bus.be}, {28'b0, e.be});
        check1("req_we", dmem_bus.we, e.we);
        check("req_wdata", dmem_bus.wdata, e.wdata);
      end
    end
    req_prev = dmem_bus.req;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1);
  end

  task automatic push_exp(input logic [31:0] addr, input logic [3:0] be, input logic we,
                          input logic [31:0] wdata);
    bus_t e;
    e.addr  = {addr[31:2], 2'b00};
    e.be    = be;
    e.we    = we;
    e.wdata = wdata;
    exp_q.push_back(e);
  endtask

  task automatic drive_inst(input logic [31:0] addr, input logic [1:0] width, input logic sx,
                            input logic rw, input logic [31:0] wdat);
    alu_res_in     = addr;
    mem_width_in   = width;
    sign_extend_in = sx;
    mem_rw_in      = rw;
    mem_write_in   = wdat;
    mem_enable_in  = 1'b1;
    wb_src_in      = ~rw;
    wb_reg_in      = ~rw;
  endtask

  task automatic run_vec(input vec_t v);
    int   stall_cnt;
    logic stable;
    stall_cnt = 0;
    stable    = 1'b1;
    @(posedge clk); #1;
    drive_inst(v.addr, v.width, v.sx, v.rw, v.wdat);
    push_exp(v.addr, v.exp_be, v.rw, v.exp_wdata);
    @(negedge clk);
    check1("aligned_no_error", addr_error, 1'b0);
    if (stall_req) stall_cnt++;
    for (int c = 0; c <= v.delay; c++) begin
      @(posedge clk); #1;
      if (c == v.delay) begin
        dmem_bus.ack   = 1'b1;
        dmem_bus.rdata = v.rdata;
      end else begin
        dmem_bus.rdata = $urandom;
      end
      @(negedge clk);
      if (stall_req) stall_cnt++;
      if (!dmem_bus.req || dmem_bus.addr !== {v.addr[31:2], 2'b00} || dmem_bus.be !== v.exp_be ||
          dmem_bus.we !== v.rw || dmem_bus.wdata !== v.exp_wdata) stable = 1'b0;
    end
    check1("bus_stable", stable, 1'b1);
    @(posedge clk); #1;
    dmem_bus.ack   = 1'b0;
    dmem_bus.rdata = $urandom;
    pipe_stall     = (v.hold != 0);
    @(negedge clk);
    check("stall_cycles", 32'(stall_cnt), 32'(v.delay + 2));
    check1("done_stall_req", stall_req, 1'b0);
    check1("done_req", dmem_bus.req, 1'b0);
    check("wb_data_done", wb_data_out, v.exp_wb);
    for (int h = 1; h <= v.hold; h++) begin
      @(posedge clk); #1;
      if (h == v.hold) pipe_stall = 1'b0;
      @(negedge clk);
      check("hold_wb_data", wb_data_out, v.exp_wb);
      check1("hold_stall_req", stall_req, 1'b0);
    end
    @(posedge clk); #1;
    mem_enable_in = 1'b0;
    alu_res_in    = $urandom;
    @(negedge clk);
    check("idle_wb_data", wb_data_out, alu_res_in);
    check1("idle_stall_req", stall_req, 1'b0);
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{32'h100, MEM_WIDTH_WORD, 1'b0, 1'b0, 32'h0,        32'hDEADBEEF, 0, 0, 4'b1111, 32'h0,        32'hDEADBEEF};
    vecs[1] = '{32'h103, MEM_WIDTH_BYTE, 1'b1, 1'b0, 32'h0,        32'h80FFFFFF, 0, 0, 4'b1000, 32'h0,        32'hFFFFFF80};
    vecs[2] = '{32'h103, MEM_WIDTH_BYTE, 1'b0, 1'b0, 32'h0,        32'h80FFFFFF, 1, 0, 4'b1000, 32'h0,        32'h00000080};
    vecs[3] = '{32'h202, MEM_WIDTH_HALF, 1'b0, 1'b1, 32'h1234ABCD, 32'h0,        5, 0, 4'b1100, 32'hABCDABCD, 32'h00000202};
    vecs[4] = '{32'h200, MEM_WIDTH_HALF, 1'b1, 1'b0, 32'h0,        32'h1234F00D, 0, 0, 4'b0011, 32'h0,        32'hFFFFF00D};
    vecs[5] = '{32'h301, MEM_WIDTH_BYTE, 1'b0, 1'b1, 32'h000000A5, 32'h0,        2, 0, 4'b0010, 32'hA5A5A5A5, 32'h00000301};
    vecs[6] = '{32'h400, 2'b11,          1'b1, 1'b0, 32'h0,        32'hCAFEBABE, 2, 0, 4'b1111, 32'h0,        32'hCAFEBABE};
    vecs[7] = '{32'h102, MEM_WIDTH_HALF, 1'b0, 1'b0, 32'h0,        32'h80011234, 0, 0, 4'b1100, 32'h0,        32'h00008001};
    vecs[8] = '{32'h500, MEM_WIDTH_WORD, 1'b0, 1'b0, 32'h0,        32'h13579BDF, 1, 4, 4'b1111, 32'h0,        32'h13579BDF};

    rst_n = 1'b0; flush = 1'b0; pipe_stall = 1'b0;
    pc_in = 32'h0000_1000; inst_in = 32'h0000_0013;
    alu_res_in = 32'h55; mem_width_in = MEM_WIDTH_WORD; sign_extend_in = 1'b0;
    mem_rw_in = 1'b0; mem_enable_in = 1'b0; mem_write_in = 32'h0;
    wb_src_in = 1'b1; wb_reg_in = 1'b1; branch_in = 1'b1;
    virtual_write_addr_in = 5'd7; physical_write_addr_in = 6'd42; active_list_index_in = 3'd5;
    dmem_bus.ack = 1'b0; dmem_bus.rdata = 32'h0;

    // Reset state and pass-through
    #12;
    check1("rst_req", dmem_bus.req, 1'b0);
    check1("rst_we", dmem_bus.we, 1'b0);
    check("rst_addr", dmem_bus.addr, 32'h0);
    check("rst_be", {28'b0, dmem_bus.be}, 32'h0);
    check("rst_wdata", dmem_bus.wdata, 32'h0);
    check1("rst_stall_req", stall_req, 1'b0);
    check("rst_wb_data", wb_data_out, 32'h55);
    check("pass_pc", pc_out, pc_in);
    check("pass_inst", inst_out, inst_in);
    check1("pass_branch", branch_out, branch_in);
    check1("pass_wb_reg", wb_reg_out, 1'b1);
    check("pass_vreg", {27'b0, virtual_write_addr_out}, 32'd7);
    check("pass_preg", {26'b0, physical_write_addr_out}, 32'd42);
    check("pass_ali", {29'b0, active_list_index_out}, 32'd5);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Non-memory instruction
    alu_res_in = 32'hA5A5_0001;
    @(negedge clk);
    check1("nomem_stall_req", stall_req, 1'b0);
    check("nomem_wb_data", wb_data_out, 32'hA5A5_0001);

    // Aligned access table
    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Misaligned word load: no request, no stall, no writeback
    @(posedge clk); #1;
    drive_inst(32'h101, MEM_WIDTH_WORD, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check1("mis_word_error", addr_error, 1'b1);
    check1("mis_word_stall", stall_req, 1'b0);
    check1("mis_word_wb_reg", wb_reg_out, 1'b0);
    check("mis_word_wb_data", wb_data_out, 32'h101);
    repeat (3) begin
      @(negedge clk);
      check1("mis_word_no_req", dmem_bus.req, 1'b0);
    end
    @(posedge clk); #1;
    drive_inst(32'h203, MEM_WIDTH_HALF, 1'b0, 1'b1, 32'h1111);
    @(negedge clk);
    check1("mis_half_error", addr_error, 1'b1);
    check1("mis_half_stall", stall_req, 1'b0);
    @(posedge clk); #1;
    mem_enable_in = 1'b0;
    alu_res_in = 32'h101;
    mem_width_in = MEM_WIDTH_WORD;
    @(negedge clk);
    check1("nomem_unaligned_no_error", addr_error, 1'b0);
    check1("nomem_unaligned_no_req", dmem_bus.req, 1'b0);

    // Flush during WAIT: access completes, result dropped, no DONE cycle
    @(posedge clk); #1;
    drive_inst(32'h600, MEM_WIDTH_WORD, 1'b0, 1'b0, 32'h0);
    push_exp(32'h600, 4'b1111, 1'b0, 32'h0);
    @(negedge clk);
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    check1("flush_wait_stall", stall_req, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      flush = 1'b0;
      mem_enable_in = 1'b0;
      if (c == 2) begin
        dmem_bus.ack   = 1'b1;
        dmem_bus.rdata = 32'h0BAD_0BAD;
      end
      @(negedge clk);
      check1("discard_stall", stall_req, 1'b1);
      check1("discard_wb_reg", wb_reg_out, 1'b0);
    end
    @(posedge clk); #1;
    dmem_bus.ack = 1'b0;
    @(negedge clk);
    check1("discard_end_stall", stall_req, 1'b0);
    check1("discard_end_req", dmem_bus.req, 1'b0);
    check("discard_no_done", wb_data_out, 32'h600);
    check1("discard_cleared_wb_reg", wb_reg_out, 1'b1);
    repeat (2) begin
      @(negedge clk);
      check1("discard_no_reissue", dmem_bus.req, 1'b0);
    end

    // Ack while idle is ignored
    @(posedge clk); #1;
    dmem_bus.ack = 1'b1;
    @(posedge clk); #1;
    dmem_bus.ack = 1'b0;
    @(negedge clk);
    check("idle_ack_ignored", wb_data_out, alu_res_in);
    check1("idle_ack_no_stall", stall_req, 1'b0);

    // Reset asserted mid-WAIT drops the request immediately
    @(posedge clk); #1;
    drive_inst(32'h700, MEM_WIDTH_WORD, 1'b0, 1'b1, 32'h11223344);
    push_exp(32'h700, 4'b1111, 1'b1, 32'h11223344);
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    check1("rstwait_req_before", dmem_bus.req, 1'b1);
    #2;
    rst_n = 1'b0;
    mem_enable_in = 1'b0;
    #1;
    check1("rstwait_req", dmem_bus.req, 1'b0);
    check1("rstwait_we", dmem_bus.we, 1'b0);
    check("rstwait_addr", dmem_bus.addr, 32'h0);
    check1("rstwait_stall", stall_req, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check1("after_rst_req", dmem_bus.req, 1'b0);
    check1("after_rst_stall", stall_req, 1'b0);

    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
Memory-access stage; sits between pipeline_exec2mem and the mem-to-writeback pipeline register. Issues loads and stores to the data-memory port with a req/ack handshake. Generates byte enables and aligned store data, and extracts, aligns and sign/zero-extends load data. Holds the pipeline via stall_req until the access completes; flags misaligned accesses.

Parameters:
ADDR_WIDTH, 32, byte address width (fixed 32 in this design)
DATA_WIDTH, 32, data width (fixed 32; 4 byte lanes)
FREE_LIST_WIDTH, 3, active-list index width (pass-through)

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
flush  in  1  kill the instruction currently in this stage
pipe_stall  in  1  downstream/global stall; instruction must stay in stage
pc_in, inst_in  in  32 each  from exec2mem, passed through to pc_out/inst_out
alu_res_in  in  32  effective address, or ALU result
mem_width_in  in  2  00 byte, 01 half, 10 word, 11 treated as word
sign_extend_in  in  1  load sign-extend when 1
mem_rw_in  in  1  1 store, 0 load
mem_enable_in  in  1  access requested
mem_write_in  in  32  store data (low bits significant)
wb_src_in  in  1  1 write back load data, 0 alu_res
wb_reg_in, branch_in, virtual_write_addr_in (`VREG_BUS), physical_write_addr_in (`PREG_BUS), active_list_index_in (FREE_LIST_WIDTH)  in  pass-through to *_out
dmem_req  out  1  registered request
dmem_we  out  1  registered write enable
dmem_addr  out  32  registered word address {alu_res[31:2],2'b00}
dmem_be  out  4  registered byte enables
dmem_wdata  out  32  registered lane-replicated store data
dmem_rdata  in  32  read data, valid with ack
dmem_ack  in  1  one-cycle completion pulse
wb_data_out  out  32  writeback value
stall_req  out  1  to hazard unit; freeze stages upstream of and including exec2mem
addr_error  out  1  misaligned access, combinational
pc_out ... active_list_index_out  out  pass-through, combinational

Behaviour:
- Reset: state=IDLE, dmem_req/we=0, dmem_addr/be/wdata=0, load_q=0, discard=0. Pass-through outputs follow inputs (exec2mem resets them to 0).
- Misaligned: half with addr[0]=1, or word with addr[1:0]!=0, while mem_enable_in=1 -> addr_error=1, no request issued, stall_req=0, wb_reg_out forced 0.
- FSM IDLE: if mem_enable_in & !addr_error & !flush -> stall_req=1. Next edge: state WAIT, dmem_req=1, dmem_we=mem_rw_in, and dmem_addr/be/wdata registered.
- Byte enables (little-endian): byte = 1<<addr[1:0], wdata={4{d[7:0]}}; half = addr[1]?1100:0011, wdata={2{d[15:0]}}; word = 1111, wdata=d. Loads drive the same be.
- WAIT: stall_req=1. Bus outputs held stable until an edge samples dmem_ack=1. On that edge: dmem_req<=0, dmem_we<=0, load_q<=extracted rdata, state<=discard?IDLE:DONE, discard<=0.
- Load extract: select lane by addr[1:0] (byte) or addr[1] (half); sign-extend if sign_extend_in, else zero-extend.
- DONE: stall_req=0. Stay in DONE while pipe_stall=1. Next edge with pipe_stall=0 -> IDLE.
- Minimum load/store occupancy: 3 cycles (IDLE, WAIT with same-cycle ack, DONE); 2 stall cycles.
- wb_data_out = (wb_src_in & state==DONE) ? load_q : alu_res_in.
- Flush:
  - IDLE or DONE: go/stay IDLE; no request.
  - WAIT: the transaction cannot be cancelled. Set discard=1 and keep stall_req=1 until ack, then return to IDLE; load data is dropped.
  - While discard=1, wb_reg_out=0.
- Non-memory instructions (mem_enable_in=0): stay IDLE, stall_req=0, and wb_data_out = alu_res_in.
- Reset asserted mid-WAIT: return to IDLE immediately and drop req. The memory side is reset by the same rst_n.
- ack while in IDLE/DONE: ignored.

Decomposition:
- Add to defines.v: MEM_WIDTH_BYTE/HALF/WORD codes, FSM state encodings (2 bits), and BE constants.
- One natural sub-module: mem_align (combinational) for be/wdata generation, load extraction and misalignment check; the FSM lives in mem_access_stage.

Test Plan:
- Word load, alu_res=0x100, ack one cycle after req: dmem_addr=0x100, be=1111, stall_req high for 2 cycles; rdata=0xDEADBEEF -> wb_data_out=0xDEADBEEF in DONE.
- Byte load signed, addr=0x103, rdata=0x80FFFFFF: be=1000 -> wb_data_out=0xFFFFFF80. Unsigned -> 0x00000080.
- Half store, addr=0x202, data=0x1234ABCD: be=1100, wdata=0xABCDABCD, we=1; ack delayed 5 cycles -> stall_req high all 6 WAIT cycles, bus outputs stable throughout.
- Word load, addr=0x101: addr_error=1, dmem_req stays 0, stall_req=0, wb_reg_out=0.
- Flush during WAIT, ack 3 cycles later: stall_req stays high until ack, state returns to IDLE, wb_reg_out=0, no DONE cycle.
- DONE with pipe_stall=1 for 4 cycles: wb_data_out holds load_q; no new request; IDLE after pipe_stall drops. Reset mid-WAIT -> dmem_req=0 immediately.
